// File: rtl/mem_burst_ctrl_pkg.sv
// mem_burst_ctrl_pkg: default widths and FSM state encoding shared by the burst controller files
package mem_burst_ctrl_pkg;
  localparam int DEF_ADDRESS_LENGTH = 6;
  localparam int DEF_DATA_LENGTH = 8;
  localparam int DEF_LEN_LENGTH = 6;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    VERIFY = 3'd2,
    READ   = 3'd3,
    RDRAIN = 3'd4,
    DONE   = 3'd5
  } state_t;
endpackage

// File: rtl/mem_burst_addrgen.sv
// mem_burst_addrgen: burst address/count registers with load, step and last-word flag
module mem_burst_addrgen
  import mem_burst_ctrl_pkg::*;
#(
  parameter int address_length = DEF_ADDRESS_LENGTH,
  parameter int len_length = DEF_LEN_LENGTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [address_length-1:0] load_addr,
  input  logic [len_length-1:0]     load_cnt,
  output logic [address_length-1:0] addr,
  output logic [len_length-1:0]     cnt,
  output logic                      last
);
  assign last = cnt == '0;
  // load starts a burst; step advances the address (wrapping) and counts down to the last word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      cnt <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt <= load_cnt;
    end else if (step) begin
      addr <= addr + address_length'(1);
      if (!last) cnt <= cnt - len_length'(1);
    end
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst initiator on a single-port RAM; optional write-verify via MEMCTL_WRITE_VERIFY_EN
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int address_length = DEF_ADDRESS_LENGTH,
  parameter int data_length = DEF_DATA_LENGTH,
  parameter int len_length = DEF_LEN_LENGTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [address_length-1:0] req_addr,
  input  logic [len_length-1:0]     req_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [data_length-1:0]    wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [data_length-1:0]    rd_data,
  output logic                      done,
  output logic                      err,
  output logic                      wren,
  output logic [address_length-1:0] address,
  output logic [data_length-1:0]    write_data,
  input  logic [data_length-1:0]    read_data
);
  state_t state;
  logic [address_length-1:0] addr_q;
  logic [len_length-1:0] cnt_q;
  logic last, load, step, issue;
  assign req_ready = state == IDLE;
  assign wr_ready = state == WRITE;
  assign wren = wr_ready && wr_valid;
  assign write_data = wr_data;
  assign address = req_ready ? req_addr : addr_q;
  assign load = req_ready && req_valid;
  assign issue = state == READ && (!rd_valid || rd_ready);
`ifdef MEMCTL_WRITE_VERIFY_EN
  logic [data_length-1:0] saved_q;
  // the address advances only after the verify cycle, so VERIFY reads back addr_q
  assign step = state == VERIFY || issue;
`else
  assign step = wren || issue;
`endif
  mem_burst_addrgen #(
    .address_length(address_length),
    .len_length(len_length)
  ) u_addrgen (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .step(step),
    .load_addr(req_addr),
    .load_cnt(req_len),
    .addr(addr_q),
    .cnt(cnt_q),
    .last(last)
  );
  // burst sequencing plus registered read stream, done pulse and sticky verify error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rd_valid <= 1'b0;
      rd_data <= '0;
      done <= 1'b0;
      err <= 1'b0;
`ifdef MEMCTL_WRITE_VERIFY_EN
      saved_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (issue) begin
        rd_data <= read_data;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
      case (state)
        IDLE:
          if (req_valid) begin
            err <= 1'b0;
            state <= req_write ? WRITE : READ;
          end
        WRITE:
          if (wr_valid) begin
`ifdef MEMCTL_WRITE_VERIFY_EN
            saved_q <= wr_data;
            state <= VERIFY;
`else
            if (last) begin
              state <= DONE;
              done <= 1'b1;
            end
`endif
          end
`ifdef MEMCTL_WRITE_VERIFY_EN
        VERIFY: begin
          if (read_data != saved_q) err <= 1'b1;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= WRITE;
          end
        end
`endif
        READ:
          if (issue && last) state <= RDRAIN;
        RDRAIN:
          if (rd_ready) begin
            state <= DONE;
            done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized self-checking bench with a RAM model and a reference memory image
module tb_mem_burst_ctrl;
  localparam int AL = 6, DL = 8, LL = 6, N = 64;
`ifdef MEMCTL_WRITE_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [AL-1:0] req_addr = '0;
  logic [LL-1:0] req_len = '0;
  logic [DL-1:0] wr_data = '0;
  logic req_ready, wr_ready, rd_valid, done, err, wren;
  logic [DL-1:0] rd_data, write_data, read_data;
  logic [AL-1:0] address;
  logic [DL-1:0] mem [N];
  logic [DL-1:0] ref_mem [N];
  logic corrupt = 1'b0, fill_en = 1'b0;
  logic [AL-1:0] fill_a = '0;
  logic [DL-1:0] fill_d = '0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.address_length(AL), .data_length(DL), .len_length(LL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .wren(wren), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  assign read_data = mem[address] ^ ((corrupt && address == AL'(7)) ? 8'h5A : 8'h00);
  always @(posedge clk)
    if (wren) mem[address] <= write_data;
    else if (fill_en) mem[fill_a] <= fill_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_req(input int a, input int l, input bit w);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = AL'(a); req_len = LL'(l);
    #1 chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = AL'($urandom);
  endtask

  task automatic finish_burst(input string tag);
    #1 chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_idle"}, req_ready, 1);
  endtask

  task automatic wr_burst(input int a, input int l, input bit gaps, input logic [DL-1:0] d [$]);
    int i = 0, cyc = 0, lat = 0;
    bit hs, prev_hs = 1'b0;
    start_req(a, l, 1'b1);
    while (i <= l && cyc < 400) begin
      wr_valid = gaps ? 1'($urandom % 2) : 1'b1;
      wr_data = d[i];
      #1;
      chk("wr_ready", wr_ready, VERIFY_EN ? !prev_hs : 1'b1);
      chk("wr_wren", wren, wr_valid && wr_ready);
      chk("busy_req_ready", req_ready, 0);
      chk("wr_done_early", done, 0);
      if (!wr_ready) chk("verify_addr", address, (a + i - 1) % N);
      hs = wr_valid && wr_ready;
      if (hs) begin
        chk("wr_addr", address, (a + i) % N);
        chk("wr_data", write_data, d[i]);
        ref_mem[(a + i) % N] = d[i];
        i++;
      end
      prev_hs = hs;
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    chk("wr_words", i, l + 1);
    #1;
    while (!done && lat < 10) begin
      @(negedge clk);
      #1 lat++;
    end
    chk("wr_done_latency", lat, VERIFY_EN ? 1 : 0);
    @(negedge clk);
    finish_burst("wr");
  endtask

  task automatic rd_burst(input int a, input int l, input int mode);
    int n = 0, cyc = 0;
    logic [DL-1:0] held = '0;
    bit stalled = 1'b0;
    start_req(a, l, 1'b0);
    while (n <= l && cyc < 400) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom % 2);
      #1;
      chk("rd_done_early", done, 0);
      if (stalled) begin
        chk("rd_stall_valid", rd_valid, 1);
        chk("rd_stable", rd_data, held);
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, ref_mem[(a + n) % N]);
        n++;
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    chk("rd_words", n, l + 1);
    #1 chk("rd_done", done, 1);
    chk("rd_valid_after", rd_valid, 0);
    if (mode == 0) chk("rd_cycles", cyc, l + 2);
    @(negedge clk);
    finish_burst("rd");
  endtask

  task automatic rand_data(input int l, output logic [DL-1:0] d [$]);
    d = {};
    for (int k = 0; k <= l; k++) d.push_back(DL'($urandom));
  endtask

  initial begin
    logic [DL-1:0] d [$];
    int a, l;
    fill_en = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      fill_a = AL'(k);
      fill_d = DL'($urandom);
      ref_mem[k] = fill_d;
    end
    @(negedge clk);
    fill_en = 1'b0;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wren", wren, 0);
    rst_n = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1; req_addr = AL'(33);
    #1 chk("idle_wren", wren, 0);
    chk("idle_address", address, 33);
    chk("idle_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    d = '{8'd11, 8'd22, 8'd33, 8'd44};
    wr_burst(5, 3, 1'b0, d);
    rd_burst(5, 3, 0);
    rd_burst(5, 3, 1);
    rand_data(3, d);
    wr_burst(62, 3, 1'b0, d);
    rd_burst(62, 3, 0);
    rd_burst(60, 7, 2);
    rand_data(7, d);
    start_req(20, 7, 1'b1);
    wr_valid = 1'b1; wr_data = d[0];
    @(negedge clk);
    wr_data = d[1];
    @(negedge clk);
    ref_mem[20] = d[0];
    ref_mem[21] = d[1];
    wr_data = d[2];
    rst_n = 1'b0;
    #1 chk("abort_req_ready", req_ready, 1);
    chk("abort_wren", wren, 0);
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    rd_burst(20, 3, 0);
    corrupt = 1'b1;
    rand_data(3, d);
    wr_burst(5, 3, 1'b0, d);
    #1 chk("err_after_corrupt", err, VERIFY_EN);
    corrupt = 1'b0;
    rd_burst(5, 3, 0);
    chk("err_cleared", err, 0);
    for (int t = 0; t < 10; t++) begin
      a = int'($urandom_range(0, N - 1));
      l = int'($urandom_range(0, 15));
      if ($urandom % 2) begin
        rand_data(l, d);
        wr_burst(a, l, 1'($urandom % 2), d);
      end else begin
        rd_burst(a, l, 2);
      end
      chk("rand_err", err, 0);
    end
    rd_burst(0, 63, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
